reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
- Write-side controller for the integer register file. It drives the file's single write port: enable_reg_write, addr_write and write_data.
- Merges three result sources into one register write per cycle:
  - the single-cycle ALU path, which has no backpressure;
  - the load unit and the multicycle (mul/div) unit, both over valid/ready.
- Long-latency results are buffered in a small FIFO.
- Keeps a pending-destination scoreboard (busy_mask) that the issue stage uses to stall RAW hazards.

Parameters:
- DEPTH, 4, entries in the long-latency result FIFO (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive ALU-priority cycles with a non-empty FIFO before stall_req is asserted.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted this cycle (combinational).
- mem_rd  in  5  load destination.
- mem_data  in  32  load data.
- mul_valid  in  1  mul/div result valid.
- mul_ready  out  1  mul/div result accepted this cycle (combinational).
- mul_rd  in  5  mul/div destination.
- mul_data  in  32  mul/div result.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_rd  in  5  destination of that op.
- enable_reg_write  out  1  registered write enable to the register file.
- addr_write  out  5  registered write address.
- write_data  out  32  registered write data.
- busy_mask  out  32  bit i = result for xi is outstanding; bit 0 is always 0.
- stall_req  out  1  registered request for the pipeline to insert an ALU bubble.

Behaviour:
- **Reset (async, reset_n=0):**
  - enable_reg_write, addr_write, write_data, busy_mask and stall_req are 0.
  - FIFO is empty, starve counter is 0, round-robin pointer favours mem.
  - Reset mid-operation discards FIFO contents and pending bits.
- **Write-port timing:** outputs are registered and change only on posedge. The register file samples them on the following negedge, so it writes in the same cycle they are presented.
- **Source selection, each cycle, in priority order:**
  - alu_valid=1 → write port loads {1, alu_rd, alu_data} at the next edge. Latency is 1 cycle.
  - else FIFO non-empty → dequeue head; the write port loads that entry.
  - else enable_reg_write → 0; addr_write and write_data hold their values.
- **rd = 0:** the entry is consumed or accepted as normal, but enable_reg_write is driven 0 for it.
- **FIFO enqueue:** at most one enqueue per cycle.
  - mem_ready = (count<DEPTH) && (!mul_valid || rr==MEM).
  - mul_ready = (count<DEPTH) && (!mem_valid || rr==MUL).
  - On an enqueue, rr flips only if both sources were valid.
- **FIFO full:** count==DEPTH → both readies are 0, even if a dequeue happens the same cycle. No pass-through.
- **Enqueue-to-write latency:** enqueue at edge N → earliest write-port presentation at edge N+1 (2 cycles from valid). Enqueue and dequeue in the same cycle are allowed when the FIFO is not full.
- **Scoreboard:**
  - issue_valid with issue_rd≠0 sets busy_mask[issue_rd] at the next edge.
  - A FIFO entry written to the port clears busy_mask[rd] at the same edge.
  - If a set and a clear target the same rd in one cycle, the set wins.
  - ALU writes never touch busy_mask. A WAW to a pending rd is allowed; the later long-latency write still lands.
- **Starvation:**
  - The counter increments each cycle that alu_valid=1 and the FIFO is non-empty.
  - It resets to 0 on any cycle that dequeues, or when the FIFO is empty.
  - It saturates at STARVE_LIMIT.
- **stall_req:** registered = (count_next==DEPTH) || (starve_next==STARVE_LIMIT).
  - The pipeline must hold alu_valid=0 while stall_req=1.
  - If alu_valid arrives anyway, the ALU still wins and no data is lost.
- **Ordering:** FIFO output order equals acceptance order.

Test Plan:
- **ALU path:** alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 → {1,5,0xDEADBEEF} on the write port after edge 1; x5 reads 0xDEADBEEF after the next negedge.
- **Round-robin arbitration:** mem and mul both valid for 2 cycles (mem rd=6/0x11, mul rd=7/0x22) with issue of x6 and x7 beforehand → mem accepted first, then mul. Writes x6=0x11 then x7=0x22. busy_mask bits 6 and 7 set then cleared in order; final busy_mask=0.
- **Full/backpressure/starvation:** alu_valid=1 every cycle while 4 mem results are enqueued →
  - FIFO full after 4 accepts; mem_ready=0 and stall_req=1;
  - with alu_valid held at 1 for 8 cycles and the FIFO non-empty, stall_req stays 1 (starve counter saturated at 8);
  - dropping alu_valid drains the 4 entries in order on 4 consecutive writes.
- **rd=0 and set-wins:** mul result rd=0 data=0x55 → consumed, enable_reg_write=0, x0 stays 0. In the same cycle that pending x9 is written back, a new issue to x9 arrives → busy_mask[9] remains 1.
- **Mid-operation reset:** assert reset_n=0 mid-drain with 3 FIFO entries and busy_mask=0x00000380 → all outputs 0 immediately, without waiting for a clock edge. After release, no stale writes occur; busy_mask=0 and mem_ready=1.

Source files
------------

// File: rtl/reg_writeback_ctrl_if.sv
// Result/write-port bundle for reg_writeback_ctrl.
//   alu_*   : single-cycle ALU result, no backpressure
//   mem_*   : load-unit result, valid/ready
//   mul_*   : mul/div result, valid/ready
//   issue_* : long-latency issue notification (sets the scoreboard)
//   enable_reg_write/addr_write/write_data : register-file write port
//   busy_mask/stall_req : scoreboard and ALU-bubble request to issue
// slave is the controller side; master is the pipeline/testbench side.
interface reg_writeback_ctrl_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_rd;
  logic [31:0] mul_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        enable_reg_write;
  logic [4:0]  addr_write;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic        stall_req;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  mul_valid, mul_rd, mul_data,
    input  issue_valid, issue_rd,
    output mem_ready, mul_ready,
    output enable_reg_write, addr_write, write_data,
    output busy_mask, stall_req
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output mul_valid, mul_rd, mul_data,
    output issue_valid, issue_rd,
    input  mem_ready, mul_ready,
    input  enable_reg_write, addr_write, write_data,
    input  busy_mask, stall_req
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-side controller.
// Merges ALU (highest priority, always accepted) with load and mul/div
// results (round-robin into a DEPTH-entry FIFO) onto one registered write
// port, tracks pending long-latency destinations in busy_mask, and raises
// stall_req when the FIFO fills or has been starved by the ALU for
// STARVE_LIMIT cycles.
// Ports: clk, reset_n (async, active low), wb (reg_writeback_ctrl_if.slave).
module reg_writeback_ctrl #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reg_writeback_ctrl_if.slave  wb
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {RR_MEM = 1'b0, RR_MUL = 1'b1} rr_e;

  wb_entry_t     fifo_q [DEPTH];
  wb_entry_t     enq_entry, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [SW-1:0] starve, starve_next;
  rr_e           rr;
  logic          full, mem_acc, mul_acc, enq, deq;
  logic [31:0]   set_vec, clr_vec, busy, busy_next;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          stall;

  // Full FIFO blocks both sources even if a dequeue frees a slot this cycle.
  assign full         = (count == FULL_CNT);
  assign wb.mem_ready = !full && (!wb.mul_valid || rr == RR_MEM);
  assign wb.mul_ready = !full && (!wb.mem_valid || rr == RR_MUL);
  assign mem_acc      = wb.mem_valid && wb.mem_ready;
  assign mul_acc      = wb.mul_valid && wb.mul_ready;
  assign enq          = mem_acc || mul_acc;
  assign head         = fifo_q[rd_ptr];
  // ALU owns the port whenever valid; the FIFO drains only in ALU gaps.
  assign deq          = !wb.alu_valid && (count != '0);
  assign count_next   = count + CW'(enq) - CW'(deq);

  always_comb begin
    enq_entry = mem_acc ? wb_entry_t'{wb.mem_rd, wb.mem_data}
                        : wb_entry_t'{wb.mul_rd, wb.mul_data};
  end

  // Counts only while the ALU holds off a non-empty FIFO; any other cycle
  // either dequeues or has nothing queued, both of which clear it.
  always_comb begin
    starve_next = '0;
    if (wb.alu_valid && count != '0)
      starve_next = (starve == STARVE_MAX) ? starve : starve + SW'(1);
  end

  // Set applied after clear so a same-cycle reissue keeps the bit pending.
  always_comb begin
    set_vec   = (wb.issue_valid && wb.issue_rd != 5'd0) ? (32'(1) << wb.issue_rd) : '0;
    clr_vec   = deq ? (32'(1) << head.rd) : '0;
    busy_next = ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= enq_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      starve  <= '0;
      rr      <= RR_MEM;
      busy    <= '0;
      stall   <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      count  <= count_next;
      starve <= starve_next;
      busy   <= busy_next;
      stall  <= (count_next == FULL_CNT) || (starve_next == STARVE_MAX);
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (wb.mem_valid && wb.mul_valid) rr <= (rr == RR_MEM) ? RR_MUL : RR_MEM;
      end
      if (wb.alu_valid) begin
        wr_en   <= (wb.alu_rd != 5'd0);
        wr_addr <= wb.alu_rd;
        wr_data <= wb.alu_data;
      end else if (deq) begin
        rd_ptr  <= rd_ptr + PW'(1);
        wr_en   <= (head.rd != 5'd0);
        wr_addr <= head.rd;
        wr_data <= head.data;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

  assign wb.enable_reg_write = wr_en;
  assign wb.addr_write       = wr_addr;
  assign wb.write_data       = wr_data;
  assign wb.busy_mask        = busy;
  assign wb.stall_req        = stall;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed testbench for reg_writeback_ctrl with a negedge-sampling
// register-file model on the write port.
module tb_reg_writeback_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus();

  reg_writeback_ctrl #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .wb(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];
  int nwrites = 0;

  // Register file: samples the write port on negedge, like the real one.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.enable_reg_write) begin
      rf[bus.addr_write] <= bus.write_data;
      nwrites <= nwrites + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.mul_valid = 0; bus.mul_rd = 0; bus.mul_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    #12;
    checks++; if (bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL rst_en got=%0b exp=0", bus.enable_reg_write); end
    checks++; if (bus.addr_write !== 5'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus.addr_write); end
    checks++; if (bus.write_data !== 32'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.write_data); end
    checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL rst_busy got=%h exp=0", bus.busy_mask); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", bus.stall_req); end
    bus.mem_valid = 1; bus.mul_valid = 1;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_rr_mem_ready got=%0b exp=1", bus.mem_ready); end
    checks++; if (bus.mul_ready !== 1'b0) begin errors++; $display("FAIL rst_rr_mul_ready got=%0b exp=0", bus.mul_ready); end
    bus.mem_valid = 0; bus.mul_valid = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 0;
    checks++; if (bus.enable_reg_write !== 1'b1) begin errors++; $display("FAIL alu_en got=%0b exp=1", bus.enable_reg_write); end
    checks++; if (bus.addr_write !== 5'd5) begin errors++; $display("FAIL alu_addr got=%0d exp=5", bus.addr_write); end
    checks++; if (bus.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got=%h exp=deadbeef", bus.write_data); end
    @(negedge clk); #1;
    checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rf_x5 got=%h exp=deadbeef", rf[5]); end
    tick();
    checks++; if (bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL idle_en got=%0b exp=0", bus.enable_reg_write); end
    checks++; if (bus.addr_write !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold got=%0d/%h exp=5/deadbeef", bus.addr_write, bus.write_data); end
  endtask

  task automatic test_round_robin();
    bus.issue_valid = 1; bus.issue_rd = 6;
    tick();
    checks++; if (bus.busy_mask !== 32'h40) begin errors++; $display("FAIL rr_busy6 got=%h exp=40", bus.busy_mask); end
    bus.issue_rd = 7;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.busy_mask !== 32'hC0) begin errors++; $display("FAIL rr_busy67 got=%h exp=c0", bus.busy_mask); end
    bus.mem_valid = 1; bus.mem_rd = 6; bus.mem_data = 32'h11;
    bus.mul_valid = 1; bus.mul_rd = 7; bus.mul_data = 32'h22;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mul_ready !== 1'b0) begin errors++; $display("FAIL rr_first got=%0b%0b exp=10", bus.mem_ready, bus.mul_ready); end
    tick();
    checks++; if (bus.mem_ready !== 1'b0 || bus.mul_ready !== 1'b1) begin errors++; $display("FAIL rr_second got=%0b%0b exp=01", bus.mem_ready, bus.mul_ready); end
    checks++; if (bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL rr_no_passthru got=%0b exp=0", bus.enable_reg_write); end
    tick();
    bus.mem_valid = 0; bus.mul_valid = 0;
    checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'd6 || bus.write_data !== 32'h11) begin errors++; $display("FAIL rr_wr6 got=%0b/%0d/%h exp=1/6/11", bus.enable_reg_write, bus.addr_write, bus.write_data); end
    checks++; if (bus.busy_mask !== 32'h80) begin errors++; $display("FAIL rr_busy7 got=%h exp=80", bus.busy_mask); end
    tick();
    checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'd7 || bus.write_data !== 32'h22) begin errors++; $display("FAIL rr_wr7 got=%0b/%0d/%h exp=1/7/22", bus.enable_reg_write, bus.addr_write, bus.write_data); end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("FAIL rr_busy0 got=%h exp=0", bus.busy_mask); end
    tick();
    checks++; if (bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL rr_drained got=%0b exp=0", bus.enable_reg_write); end
    checks++; if (rf[6] !== 32'h11 || rf[7] !== 32'h22) begin errors++; $display("FAIL rr_rf got=%h/%h exp=11/22", rf[6], rf[7]); end
  endtask

  task automatic test_full_backpressure();
    bus.alu_valid = 1; bus.alu_rd = 1; bus.mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_data = 32'h100 + i; bus.mem_rd = 5'(10 + i); bus.mem_data = 32'hA0 + i;
      #1;
      checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL full_accept%0d got=%0b exp=1", i, bus.mem_ready); end
      tick();
      checks++; if (bus.addr_write !== 5'd1 || bus.write_data !== 32'h100 + i) begin errors++; $display("FAIL full_alu%0d got=%0d/%h exp=1/%h", i, bus.addr_write, bus.write_data, 32'h100 + i); end
      checks++; if (bus.stall_req !== (i == 3)) begin errors++; $display("FAIL full_stall%0d got=%0b exp=%0b", i, bus.stall_req, (i == 3)); end
    end
    bus.mem_rd = 14; bus.mem_data = 32'hEE;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", bus.mem_ready); end
    for (int i = 0; i < 8; i++) begin
      bus.alu_data = 32'h200 + i;
      tick();
      checks++; if (bus.stall_req !== 1'b1 || bus.write_data !== 32'h200 + i) begin errors++; $display("FAIL full_hold%0d got=%0b/%h exp=1/%h", i, bus.stall_req, bus.write_data, 32'h200 + i); end
    end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("FAIL full_alu_busy got=%h exp=0", bus.busy_mask); end
    bus.alu_valid = 0; bus.mem_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'(10 + i) || bus.write_data !== 32'hA0 + i) begin errors++; $display("FAIL drain%0d got=%0b/%0d/%h exp=1/%0d/%h", i, bus.enable_reg_write, bus.addr_write, bus.write_data, 10 + i, 32'hA0 + i); end
      if (i == 0) begin
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL drain_stall got=%0b exp=0", bus.stall_req); end
      end
    end
    tick();
    checks++; if (bus.enable_reg_write !== 1'b0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b/%0b exp=0/1", bus.enable_reg_write, bus.mem_ready); end
    checks++; if (rf[13] !== 32'hA3) begin errors++; $display("FAIL drain_rf got=%h exp=a3", rf[13]); end
  endtask

  task automatic test_starve();
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h400;
    bus.mem_valid = 1; bus.mem_rd = 20; bus.mem_data = 32'hC0;
    tick();
    bus.mem_valid = 0;
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_start got=%0b exp=0", bus.stall_req); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (bus.stall_req !== (k == 8)) begin errors++; $display("FAIL starve_cnt%0d got=%0b exp=%0b", k, bus.stall_req, (k == 8)); end
    end
    tick();
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_sat got=%0b exp=1", bus.stall_req); end
    bus.alu_valid = 0;
    tick();
    checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'd20 || bus.write_data !== 32'hC0 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_drain got=%0b/%0d/%h/%0b exp=1/20/c0/0", bus.enable_reg_write, bus.addr_write, bus.write_data, bus.stall_req); end
  endtask

  task automatic test_rd0_setwins();
    bus.issue_valid = 1; bus.issue_rd = 9;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.busy_mask !== 32'h200) begin errors++; $display("FAIL sw_busy9 got=%h exp=200", bus.busy_mask); end
    bus.mul_valid = 1; bus.mul_rd = 0; bus.mul_data = 32'h55;
    #1;
    checks++; if (bus.mul_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got=%0b exp=1", bus.mul_ready); end
    tick();
    bus.mul_rd = 9; bus.mul_data = 32'h99;
    tick();
    bus.mul_valid = 0;
    checks++; if (bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL rd0_en got=%0b exp=0", bus.enable_reg_write); end
    bus.issue_valid = 1; bus.issue_rd = 9;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'd9 || bus.write_data !== 32'h99) begin errors++; $display("FAIL sw_wr9 got=%0b/%0d/%h exp=1/9/99", bus.enable_reg_write, bus.addr_write, bus.write_data); end
    checks++; if (bus.busy_mask !== 32'h200) begin errors++; $display("FAIL sw_setwins got=%h exp=200", bus.busy_mask); end
    tick();
    checks++; if (bus.busy_mask !== 32'h200 || bus.enable_reg_write !== 1'b0) begin errors++; $display("FAIL sw_after got=%h/%0b exp=200/0", bus.busy_mask, bus.enable_reg_write); end
    checks++; if (rf[0] !== 32'h0 || rf[9] !== 32'h99) begin errors++; $display("FAIL rd0_rf got=%h/%h exp=0/99", rf[0], rf[9]); end
  endtask

  task automatic test_mid_reset();
    int w0;
    bus.issue_valid = 1; bus.issue_rd = 7;
    tick();
    bus.issue_rd = 8;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.busy_mask !== 32'h380) begin errors++; $display("FAIL mr_busy got=%h exp=380", bus.busy_mask); end
    bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h300;
    bus.mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin bus.mem_rd = 3; bus.mem_data = 32'h33; end
        1: begin bus.mem_rd = 7; bus.mem_data = 32'hB7; end
        2: begin bus.mem_rd = 8; bus.mem_data = 32'hB8; end
        default: begin bus.mem_rd = 9; bus.mem_data = 32'hB9; end
      endcase
      tick();
    end
    bus.alu_valid = 0; bus.mem_valid = 0;
    tick();
    checks++; if (bus.enable_reg_write !== 1'b1 || bus.addr_write !== 5'd3 || bus.write_data !== 32'h33) begin errors++; $display("FAIL mr_drain got=%0b/%0d/%h exp=1/3/33", bus.enable_reg_write, bus.addr_write, bus.write_data); end
    checks++; if (bus.busy_mask !== 32'h380) begin errors++; $display("FAIL mr_busy_pre got=%h exp=380", bus.busy_mask); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.enable_reg_write !== 1'b0 || bus.addr_write !== 5'd0 || bus.write_data !== 32'd0) begin errors++; $display("FAIL mr_async_port got=%0b/%0d/%h exp=0/0/0", bus.enable_reg_write, bus.addr_write, bus.write_data); end
    checks++; if (bus.busy_mask !== 32'd0 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL mr_async_sb got=%h/%0b exp=0/0", bus.busy_mask, bus.stall_req); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    w0 = nwrites;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.enable_reg_write !== 1'b0 || bus.busy_mask !== 32'd0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL mr_post%0d got=%0b/%h/%0b exp=0/0/1", i, bus.enable_reg_write, bus.busy_mask, bus.mem_ready); end
    end
    checks++; if (nwrites !== w0) begin errors++; $display("FAIL mr_stale got=%0d exp=%0d", nwrites, w0); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_round_robin();
    test_full_backpressure();
    test_starve();
    test_rd0_setwins();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
